// File: rtl/feed_arbiter_pkg.sv
// ============================================================================
// feed_arbiter_pkg : shared types for the market-data feed arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package feed_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB = 2'd0,
        FWD = 2'd1,
        GAP = 2'd2
    } arb_state_t;

    // Width of a feed index; never zero even for a degenerate single feed.
    function automatic int feed_id_w(input int num_feeds);
        return (num_feeds > 1) ? $clog2(num_feeds) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational rotate-priority pick starting after 'last'
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import feed_arbiter_pkg::*;
#(
    parameter int NUM_FEEDS = 4,
    parameter int ID_W      = feed_id_w(NUM_FEEDS)
) (
    input  logic [NUM_FEEDS-1:0] req,
    input  logic [ID_W-1:0]      last,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 gnt_valid
);

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NUM_FEEDS;
    endfunction

    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        // Scan farthest-first so the requester nearest after 'last' overwrites the rest.
        for (int k = NUM_FEEDS; k >= 1; k--) begin
            if (req[wrap_idx(int'(last), k)]) begin
                gnt_id    = ID_W'(wrap_idx(int'(last), k));
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/feed_arbiter.sv
// ============================================================================
// feed_arbiter : round-robin, message-locked sharing of one byte parser
// Rev 1.0
// ============================================================================
`default_nettype none

module feed_arbiter
    import feed_arbiter_pkg::*;
#(
    parameter int NUM_FEEDS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_FEEDS-1:0][7:0]    feed_byte,
    input  logic [NUM_FEEDS-1:0]         feed_valid,
    input  logic [NUM_FEEDS-1:0]         feed_last,
    output logic [NUM_FEEDS-1:0]         feed_ready,
    input  logic                         fifo_full,
    output logic [7:0]                   byte_out,
    output logic                         byte_valid_out,
    output logic [$clog2(NUM_FEEDS)-1:0] grant_id,
    output logic                         busy,
    output logic [CNT_W-1:0]             msg_count
);

    localparam int                   FEED_ID_W    = feed_id_w(NUM_FEEDS);
    localparam logic [FEED_ID_W-1:0] C_LAST_RESET = FEED_ID_W'(NUM_FEEDS - 1);

    arb_state_t           r_state;
    logic [FEED_ID_W-1:0] r_last;
    logic [FEED_ID_W-1:0] w_gnt_id;
    logic                 w_gnt_valid;
    logic                 w_accept;
    logic                 w_accept_last;

    rr_arbiter #(
        .NUM_FEEDS (NUM_FEEDS),
        .ID_W      (FEED_ID_W)
    ) u_rr (
        .req       (feed_valid),
        .last      (r_last),
        .gnt_id    (w_gnt_id),
        .gnt_valid (w_gnt_valid)
    );

    always_comb begin
        feed_ready = '0;
        if (r_state == FWD) begin
            feed_ready[grant_id] = 1'b1;
        end
    end

    assign w_accept      = (r_state == FWD) && feed_valid[grant_id];
    assign w_accept_last = w_accept && feed_last[grant_id];
    assign busy          = (r_state == FWD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ARB;
            r_last         <= C_LAST_RESET;
            grant_id       <= '0;
            byte_out       <= '0;
            byte_valid_out <= 1'b0;
            msg_count      <= '0;
        end else begin
            byte_valid_out <= w_accept;
            if (w_accept) begin
                byte_out <= feed_byte[grant_id];
            end
            case (r_state)
                ARB: begin
                    // A full message FIFO blocks only the start of a new message.
                    if (!fifo_full && w_gnt_valid) begin
                        grant_id <= w_gnt_id;
                        r_last   <= w_gnt_id;
                        r_state  <= FWD;
                    end
                end
                FWD: begin
                    if (w_accept_last) begin
                        msg_count <= msg_count + CNT_W'(1);
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    r_state <= ARB;
                end
                default: begin
                    r_state <= ARB;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_feed_arbiter.sv
// ============================================================================
// tb_feed_arbiter : scoreboard bench for feed_arbiter with a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_feed_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0][7:0] feed_byte;
    logic [N-1:0]      feed_valid;
    logic [N-1:0]      feed_last;
    logic [N-1:0]      feed_ready;
    logic              fifo_full;
    logic [7:0]        byte_out;
    logic              byte_valid_out;
    logic [IDW-1:0]    grant_id;
    logic              busy;
    logic [CW-1:0]     msg_count;

    feed_arbiter #(.NUM_FEEDS(N), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .feed_byte      (feed_byte),
        .feed_valid     (feed_valid),
        .feed_last      (feed_last),
        .feed_ready     (feed_ready),
        .fifo_full      (fifo_full),
        .byte_out       (byte_out),
        .byte_valid_out (byte_valid_out),
        .grant_id       (grant_id),
        .busy           (busy),
        .msg_count      (msg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       l;
    } hs_t;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] fq[N][$];    // bytes still to be offered by each feed {last,byte}
    logic [8:0] expb[N][$];  // bytes each feed expects to see forwarded
    int         stall_cnt[N];
    int         stall_pct;
    bit         rand_full;
    logic [N-1:0] acc;
    hs_t        hq[$];
    int         glog[$];
    int         m_phase;     // 0 idle/arbitrating, 1 forwarding, 2 post-message gap
    int         m_grant;
    int         m_last;
    int         m_count;
    int         cyc = 0;
    bit         prev_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : mon
        hs_t        h;
        logic [8:0] e;
        cyc++;
        acc = '0;
        if (reset) begin
            m_phase   = 0;
            m_grant   = 0;
            m_last    = N - 1;
            m_count   = 0;
            prev_busy = 1'b0;
            hq.delete();
            glog.delete();
        end else begin
            chk("busy", busy, m_phase == 1);
            chk("feed_ready", feed_ready, (m_phase == 1) ? (1 << m_grant) : 0);
            chk("grant_id", grant_id, m_grant);
            chk("msg_count", msg_count, m_count % (1 << CW));
            if (hq.size() > 0 && hq[0].cyc == cyc - 1) begin
                h = hq.pop_front();
                chk("byte_valid_out", byte_valid_out, 1);
                chk("byte_out", byte_out, h.b);
                if (expb[m_grant].size() > 0) begin
                    e = expb[m_grant].pop_front();
                    chk("msg_byte", byte_out, e[7:0]);
                    chk("msg_last", h.l, e[8]);
                end else begin
                    chk("msg_byte_avail", 0, 1);
                end
            end else begin
                chk("byte_valid_idle", byte_valid_out, 0);
            end
            if (busy && !prev_busy) glog.push_back(int'(grant_id));
            prev_busy = busy;

            case (m_phase)
                0: if (!fifo_full && (|feed_valid)) begin
                    m_grant = rr_pick(feed_valid, m_last);
                    m_last  = m_grant;
                    m_phase = 1;
                end
                1: if (feed_valid[m_grant]) begin
                    acc[m_grant] = 1'b1;
                    hq.push_back('{cyc, feed_byte[m_grant], feed_last[m_grant]});
                    if (feed_last[m_grant]) begin
                        m_count++;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
        for (int f = 0; f < N; f++) begin
            if (acc[f] && fq[f].size() > 0) void'(fq[f].pop_front());
            if (stall_cnt[f] > 0) begin
                stall_cnt[f]--;
                feed_valid[f] = 1'b0;
                feed_byte[f]  = 8'($urandom);
                feed_last[f]  = 1'($urandom);
            end else if (fq[f].size() > 0 && int'($urandom_range(99)) >= stall_pct) begin
                feed_valid[f] = 1'b1;
                feed_byte[f]  = fq[f][0][7:0];
                feed_last[f]  = fq[f][0][8];
            end else begin
                feed_valid[f] = 1'b0;
                feed_byte[f]  = 8'($urandom);
                feed_last[f]  = 1'($urandom);
            end
        end
        if (rand_full && $urandom_range(9) == 0) fifo_full = ~fifo_full;
    endtask

    task automatic send(input int f, input int len, input int base);
        logic [8:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == len - 1), 8'(base + i)};
            fq[f].push_back(w);
            expb[f].push_back(w);
        end
    endtask

    function automatic bit idle();
        for (int f = 0; f < N; f++) if (fq[f].size() > 0) return 1'b0;
        return (m_phase == 0) && (hq.size() == 0);
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (n < budget && !idle()) begin
            drive();
            n++;
        end
        repeat (2) drive();
        chk(name, n < budget, 1);
    endtask

    task automatic chk_glog(input string name, input int i, input int v);
        chk(name, (glog.size() > i) ? glog[i] : 99, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        fifo_full  = 1'b0;
        feed_valid = '0;
        feed_last  = '0;
        feed_byte  = '0;
        stall_pct  = 0;
        rand_full  = 1'b0;
        for (int f = 0; f < N; f++) stall_cnt[f] = 0;
        repeat (3) drive();
        reset = 1'b0;
        chk("rst_feed_ready", feed_ready, 0);
        chk("rst_byte_valid", byte_valid_out, 0);
        chk("rst_byte_out", byte_out, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_msg_count", msg_count, 0);
        repeat (3) drive();

        // Round robin among feeds 0,1,3 with two 2-byte messages each.
        send(0, 2, 8'h00); send(1, 2, 8'h10); send(3, 2, 8'h30);
        send(0, 2, 8'h02); send(1, 2, 8'h12); send(3, 2, 8'h32);
        drain("rr_drain", 200);
        chk_glog("rr_order0", 0, 0); chk_glog("rr_order1", 1, 1); chk_glog("rr_order2", 2, 3);
        chk_glog("rr_order3", 3, 0); chk_glog("rr_order4", 4, 1); chk_glog("rr_order5", 5, 3);
        chk("rr_msg_count", msg_count, 6);

        // Single feed message.
        glog.delete();
        send(2, 3, 8'hA1);
        drain("single_drain", 100);
        chk_glog("single_grant", 0, 2);
        chk("single_grant_id", grant_id, 2);
        chk("single_msg_count", msg_count, 7);

        // Mid-message stall on feed 1 while feed 0 waits.
        glog.delete();
        send(1, 4, 8'h20);
        n = 0;
        while (fq[1].size() == 4 && n < 50) begin drive(); n++; end
        chk("stall_start", n < 50, 1);
        stall_cnt[1] = 5;
        send(0, 2, 8'h28);
        drain("stall_drain", 200);
        chk_glog("stall_order0", 0, 1);
        chk_glog("stall_order1", 1, 0);

        // Full gating in ARB.
        fifo_full = 1'b1;
        send(0, 2, 8'h48);
        repeat (6) drive();
        chk("full_busy", busy, 0);
        chk("full_ready", feed_ready, 0);
        fifo_full = 1'b0;
        drive();
        chk("full_release_grant", busy, 1);
        drain("full_drain", 100);

        // Full rising after the first byte of a 4-byte message.
        send(3, 4, 8'h30);
        n = 0;
        while (fq[3].size() == 4 && n < 50) begin drive(); n++; end
        chk("fullmid_start", n < 50, 1);
        fifo_full = 1'b1;
        send(0, 2, 8'h40);
        repeat (12) drive();
        chk("fullmid_forwarded", fq[3].size(), 0);
        chk("fullmid_no_grant", busy, 0);
        fifo_full = 1'b0;
        drain("fullmid_drain", 100);

        // Randomized traffic with stalls and fifo_full toggling.
        stall_pct = 25;
        rand_full = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) begin
                int f;
                f = int'($urandom_range(N - 1));
                if (fq[f].size() < 16) send(f, int'($urandom_range(6, 1)), int'($urandom_range(255)));
            end
            drive();
        end
        rand_full = 1'b0;
        fifo_full = 1'b0;
        stall_pct = 0;
        drain("random_drain", 3000);

        // Reset in the middle of a 5-byte message.
        send(2, 5, 8'h50);
        n = 0;
        while (fq[2].size() == 5 && n < 50) begin drive(); n++; end
        chk("reset_start", n < 50, 1);
        reset = 1'b1;
        for (int f = 0; f < N; f++) begin
            fq[f].delete();
            expb[f].delete();
            stall_cnt[f] = 0;
        end
        drive();
        reset = 1'b0;
        chk("mrst_byte_valid", byte_valid_out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_msg_count", msg_count, 0);
        chk("mrst_grant_id", grant_id, 0);
        chk("mrst_feed_ready", feed_ready, 0);
        send(3, 2, 8'h70); send(0, 2, 8'h78); send(2, 1, 8'h7F);
        drain("mrst_drain", 100);
        chk_glog("mrst_order0", 0, 0);
        chk_glog("mrst_order1", 1, 2);
        chk_glog("mrst_order2", 2, 3);
        chk("mrst_msg_count_end", msg_count, 3);

        n = 0;
        for (int f = 0; f < N; f++) n += expb[f].size();
        chk("expected_bytes_left", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
